// File: rtl/conv_tap_sequencer.sv
// Feeds (sample, coefficient) pairs into an external signed MAC, one tap per cycle,
// and captures the accumulated FIR output once all taps have been streamed.
module conv_tap_sequencer #(
  parameter int unsigned TAPS = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               coef_wr,
  input  logic [3:0]         coef_addr,
  input  logic signed [7:0]  coef_data,
  input  logic               sample_valid,
  input  logic signed [7:0]  sample_in,
  output logic               sample_ready,
  output logic signed [7:0]  x,
  output logic signed [7:0]  y,
  output logic               AccumReset,
  input  logic signed [31:0] mac_result,
  output logic               y_valid,
  output logic signed [31:0] y_out
);

  localparam int unsigned KW    = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned DW    = 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CLEAR = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  localparam logic [KW-1:0] LAST_TAP = KW'(TAPS - 1);

  logic [1:0]           state, nxt_state;
  logic [KW-1:0]        k, nxt_k;
  logic signed [DW-1:0] d [DEPTH];
  logic signed [DW-1:0] h [DEPTH];
  logic signed [DW-1:0] nxt_x, nxt_y;
  logic                 nxt_clr, nxt_ready;
  logic                 accept, coef_en;

  assign accept  = (state == IDLE) && sample_valid;
  assign coef_en = (state == IDLE) && coef_wr && ({1'b0, coef_addr} < (KW + 1)'(TAPS));

  // Next state plus the MAC operands for that state, so all outputs leave a flop.
  always_comb begin
    nxt_state = state;
    nxt_k     = k;
    nxt_x     = '0;
    nxt_y     = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          nxt_state = CLEAR;
          nxt_k     = '0;
        end
      end
      CLEAR: begin
        nxt_state = RUN;
        nxt_k     = '0;
      end
      RUN: begin
        if (k == LAST_TAP) begin
          nxt_state = DRAIN;
        end else begin
          nxt_k = k + 4'd1;
        end
      end
      DRAIN: begin
        nxt_state = IDLE;
        nxt_k     = '0;
      end
      default: begin
        nxt_state = IDLE;
        nxt_k     = '0;
      end
    endcase
    if (nxt_state == RUN) begin
      nxt_x = d[nxt_k];
      nxt_y = h[nxt_k];
    end
    nxt_clr   = (nxt_state == CLEAR);
    nxt_ready = (nxt_state == IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      k            <= '0;
      x            <= '0;
      y            <= '0;
      AccumReset   <= 1'b0;
      sample_ready <= 1'b1;
      y_valid      <= 1'b0;
      y_out        <= '0;
    end else begin
      state        <= nxt_state;
      k            <= nxt_k;
      x            <= nxt_x;
      y            <= nxt_y;
      AccumReset   <= nxt_clr;
      sample_ready <= nxt_ready;
      y_valid      <= (state == DRAIN);
      if (state == DRAIN) begin
        y_out <= mac_result;
      end
    end
  end

  // Entries at or beyond TAPS stay zero and are never read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        d[i] <= '0;
      end
    end else if (accept) begin
      d[0] <= sample_in;
      for (int i = 1; i < DEPTH; i++) begin
        d[i] <= (i < TAPS) ? d[i-1] : '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        h[i] <= '0;
      end
    end else if (coef_en) begin
      h[coef_addr] <= coef_data;
    end
  end

endmodule

// File: tb/tb_conv_tap_sequencer.sv
// Bench for conv_tap_sequencer: behavioural MAC, expected-result queue and a y_valid monitor.
module tb_conv_tap_sequencer;

  logic               clk = 1'b0;
  logic               reset;
  logic               coef_wr;
  logic [3:0]         coef_addr;
  logic signed [7:0]  coef_data;
  logic               sample_valid;
  logic signed [7:0]  sample_in;
  logic               sample_ready;
  logic signed [7:0]  x;
  logic signed [7:0]  y;
  logic               AccumReset;
  logic signed [31:0] mac_result = 32'sd12345;
  logic               y_valid;
  logic signed [31:0] y_out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic signed [31:0] expq [$];

  logic signed [7:0]  hexp [8] = '{8'sd3, -8'sd2, 8'sd5, 8'sd7, -8'sd1, 8'sd4, -8'sd6, 8'sd2};
  logic signed [7:0]  dexp [8] = '{8'sd9, 8'sd2, 8'sd127, 8'sd127, 8'sd127, 8'sd127, 8'sd127, 8'sd127};
  int pos_exp [8] = '{98432, 65792, 33152, 512, -32128, -64768, -97408, -130048};
  int ramp_exp [9] = '{-4, 1, 1, 1, 1, 1, 1, 1, 1};

  conv_tap_sequencer #(.TAPS(8)) dut (
    .clk(clk), .reset(reset), .coef_wr(coef_wr), .coef_addr(coef_addr),
    .coef_data(coef_data), .sample_valid(sample_valid), .sample_in(sample_in),
    .sample_ready(sample_ready), .x(x), .y(y), .AccumReset(AccumReset),
    .mac_result(mac_result), .y_valid(y_valid), .y_out(y_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // MAC as seen from the sequencer; starts with garbage on purpose.
  always @(posedge clk) begin
    if (AccumReset) mac_result <= '0;
    else            mac_result <= mac_result + (32'(x) * 32'(y));
  end

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic signed [31:0] e;
    if (!reset && y_valid) begin
      if (expq.size() == 0) begin
        chk("unexpected_y_valid", 32'sd1, 32'sd0);
      end else begin
        e = expq.pop_front();
        chk("y_out", y_out, e);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!sample_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("ready_timeout", 32'sd0, 32'sd1);
  endtask

  task automatic write_coef(input logic [3:0] a, input logic signed [7:0] v);
    wait_ready();
    coef_wr   = 1'b1;
    coef_addr = a;
    coef_data = v;
    @(negedge clk);
    coef_wr   = 1'b0;
  endtask

  task automatic send_sample(input logic signed [7:0] s, input logic signed [31:0] e);
    wait_ready();
    sample_valid = 1'b1;
    sample_in    = s;
    expq.push_back(e);
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (expq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drained", 32'(expq.size()), 32'sd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_impulse();
    for (int i = 0; i < 8; i++) write_coef(4'(i), 8'(i + 1));
    send_sample(8'sd1, 32'sd1);
    for (int i = 1; i < 8; i++) send_sample(8'sd0, 32'(i + 1));
    send_sample(8'sd0, 32'sd0);
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int last_acc;
    reset = 1'b0; coef_wr = 1'b0; coef_addr = '0; coef_data = '0;
    sample_valid = 1'b0; sample_in = '0;
    #3 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_sample_ready", sample_ready, 1);
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_accum_reset", AccumReset, 0);
    chk("rst_y_valid", y_valid, 0);
    chk("rst_y_out", y_out, 0);
    reset = 1'b0;
    @(negedge clk);

    run_impulse();

    // Signed extremes: all taps -128.
    for (int i = 0; i < 8; i++) write_coef(4'(i), -8'sd128);
    for (int j = 1; j <= 8; j++) send_sample(-8'sd128, 32'(16384 * j));
    for (int j = 0; j < 8; j++) send_sample(8'sd127, 32'(pos_exp[j]));
    wait_drain();

    // Cycle accuracy on a single accept.
    for (int i = 0; i < 8; i++) write_coef(4'(i), hexp[i]);
    send_sample(8'sd2, 32'sd1149);
    wait_drain();
    wait_ready();
    sample_valid = 1'b1;
    sample_in    = 8'sd9;
    expq.push_back(32'sd1420);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c == 1) sample_valid = 1'b0;
      chk($sformatf("cyc%0d_accum_reset", c), AccumReset, (c == 1) ? 1 : 0);
      chk($sformatf("cyc%0d_sample_ready", c), sample_ready, (c == 11) ? 1 : 0);
      chk($sformatf("cyc%0d_y_valid", c), y_valid, (c == 11) ? 1 : 0);
      if (c >= 2 && c <= 9) begin
        chk($sformatf("cyc%0d_x", c), x, dexp[c-2]);
        chk($sformatf("cyc%0d_y", c), y, hexp[c-2]);
      end else begin
        chk($sformatf("cyc%0d_x", c), x, 0);
        chk($sformatf("cyc%0d_y", c), y, 0);
      end
    end
    wait_drain();

    // Back-to-back streaming with sample_valid held high.
    do_reset();
    write_coef(4'd0, 8'sd1);
    write_coef(4'd1, -8'sd1);
    last_acc = 0;
    for (int i = 0; i < 9; i++) begin
      wait_ready();
      sample_valid = 1'b1;
      sample_in    = 8'(i - 4);
      expq.push_back(32'(ramp_exp[i]));
      if (i > 0) chk("accept_spacing", 32'(cyc - last_acc), 32'sd11);
      last_acc = cyc;
      @(negedge clk);
    end
    sample_valid = 1'b0;
    wait_drain();

    // Kernel writes: same-cycle with accept, during RUN, and out of range.
    wait_ready();
    coef_wr = 1'b1; coef_addr = 4'd0; coef_data = 8'sd2;
    sample_valid = 1'b1; sample_in = 8'sd10;
    expq.push_back(32'sd16);
    @(negedge clk);
    coef_wr = 1'b0; sample_valid = 1'b0;
    repeat (2) @(negedge clk);
    coef_wr = 1'b1; coef_addr = 4'd1; coef_data = 8'sd50;
    @(negedge clk);
    coef_wr = 1'b0;
    write_coef(4'd9, 8'sd77);
    send_sample(8'sd0, -32'sd10);
    wait_drain();

    // Reset in the middle of RUN: nothing for the aborted sample.
    wait_ready();
    sample_valid = 1'b1;
    sample_in    = 8'sd5;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) sample_valid = 1'b0;
    end
    reset = 1'b1;
    #1;
    chk("midrst_x", x, 0);
    chk("midrst_y", y, 0);
    chk("midrst_accum_reset", AccumReset, 0);
    chk("midrst_sample_ready", sample_ready, 1);
    chk("midrst_y_valid", y_valid, 0);
    chk("midrst_y_out", y_out, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    run_impulse();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
